// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, the
// length-field width, and the state-to-status-output mapping.
package loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic s_ready;
    logic done;
    logic error;
    logic core_rst_n;
  } flags_t;

  // Status outputs are a pure function of the state being entered, so the top
  // can register them alongside the state and keep them glitch-free.
  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f.s_ready    = (s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK});
    f.done       = (s == ST_DONE);
    f.error      = (s == ST_ERROR);
    f.core_rst_n = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// one word at a time and releases the core reset only after a good load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  localparam int ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [31:0]      word_buf;
  logic [7:0]       checksum;
  logic             accept;
  logic             last_word;

  assign accept    = s_valid && s_ready;
  assign len_in    = {s_data, len_lo};
  assign last_word = ((word_idx + LEN_W'(1)) == len);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_in > LEN_W'(IMEM_DEPTH)) state_nxt = ST_ERROR;
          else if (len_in == '0)           state_nxt = ST_CHECK;
          else                             state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (accept && byte_cnt == 2'd3 && last_word) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (accept) state_nxt = (s_data == checksum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE,
      ST_ERROR:  if (restart) state_nxt = ST_LEN_LO;
      default:   state_nxt = ST_LEN_LO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LEN_LO;
      s_ready    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      checksum   <= '0;
    end else begin
      state <= state_nxt;
      {s_ready, done, error, core_rst_n} <= state_flags(state_nxt);
      imem_we <= 1'b0;

      unique case (state)
        ST_LEN_LO: if (accept) len_lo <= s_data;
        ST_LEN_HI: if (accept) len <= len_in;
        ST_DATA: begin
          if (accept) begin
            checksum <= checksum ^ s_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= {s_data, word_buf[23:0]};
              // The last word leaves the index at N-1; it never wraps.
              if (!last_word) word_idx <= word_idx + LEN_W'(1);
            end else begin
              word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
            end
          end
        end
        ST_DONE,
        ST_ERROR: begin
          if (restart) begin
            len_lo   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            checksum <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed streams push expected memory
// writes into a queue that a negedge monitor pops and compares.
module tb_imem_loader;

  localparam int IMEM_DEPTH = 256;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data  = 8'h00;
  logic              restart = 1'b0;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;

  imem_loader #(.IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef logic [7:0] byte_q_t[$];

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Presents one byte per cycle; with gaps, inserts up to two idle cycles.
  task automatic send(input byte_q_t bytes, input bit gaps);
    foreach (bytes[i]) begin
      @(negedge clk);
      if (gaps) begin
        for (int g = 0; g < 2 && $urandom_range(0, 1) == 1; g++) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = bytes[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic expect_status(input string tag, input logic e_done, input logic e_error,
                               input logic e_core, input logic e_ready);
    check({tag, "_done"},       done,       e_done);
    check({tag, "_error"},      error,      e_error);
    check({tag, "_core_rst_n"}, core_rst_n, e_core);
    check({tag, "_s_ready"},    s_ready,    e_ready);
  endtask

  task automatic expect_reset_values(input string tag);
    expect_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_we"},    imem_we,          1'b0);
    check({tag, "_addr"},  32'(imem_addr),   32'h0);
    check({tag, "_wdata"}, imem_wdata,       32'h0);
  endtask

  initial begin
    byte_q_t q;

    // Reset values, then s_ready rises one edge after release.
    repeat (2) @(negedge clk);
    #1;
    expect_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // Two-word load, full rate; checksum is the XOR of all eight payload bytes.
    push_wr(8'd0, 32'h0010_0513);
    push_wr(8'd1, 32'h0020_0593);
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send(q, 1'b0);
    expect_status("good2", 1'b1, 1'b0, 1'b1, 1'b0);
    check("good2_pending", 32'(exp_q.size()), 32'd0);

    // Bytes offered while s_ready is low are ignored.
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    expect_status("done_hold", 1'b1, 1'b0, 1'b1, 1'b0);

    // Restart from DONE drops core reset and re-arms next cycle.
    pulse_restart();
    expect_status("restart_done", 1'b0, 1'b0, 1'b0, 1'b1);

    // One-word reload; a restart pulse mid-DATA must be ignored.
    push_wr(8'd0, 32'h1234_5678);
    q = '{8'h01, 8'h00};
    send(q, 1'b0);
    pulse_restart();
    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send(q, 1'b0);
    expect_status("reload1", 1'b1, 1'b0, 1'b1, 1'b0);

    // Bad checksum: both writes still happen, then ERROR.
    pulse_restart();
    push_wr(8'd0, 32'h0010_0513);
    push_wr(8'd1, 32'h0020_0593);
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'h00};
    send(q, 1'b0);
    expect_status("badchk", 1'b0, 1'b1, 1'b0, 1'b0);
    check("badchk_pending", 32'(exp_q.size()), 32'd0);

    // Length beyond depth: ERROR right after LEN_HI, no writes.
    pulse_restart();
    q = '{8'h01, 8'h01};
    send(q, 1'b0);
    expect_status("toolong", 1'b0, 1'b1, 1'b0, 1'b0);

    // Empty program with the matching and a mismatching checksum.
    pulse_restart();
    q = '{8'h00, 8'h00, 8'h00};
    send(q, 1'b0);
    expect_status("len0_ok", 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_restart();
    q = '{8'h00, 8'h00, 8'h01};
    send(q, 1'b0);
    expect_status("len0_bad", 1'b0, 1'b1, 1'b0, 1'b0);

    // Gappy stream cut by reset after six payload bytes: only word 0 lands.
    pulse_restart();
    push_wr(8'd0, 32'h0010_0513);
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
    send(q, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_reset_values("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_ready, 1'b1);

    // Clean load with gaps afterwards succeeds.
    push_wr(8'd0, 32'h0010_0513);
    push_wr(8'd1, 32'h0020_0593);
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send(q, 1'b1);
    expect_status("after_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
